fp_addsub_pipe: RTL and testbench

//  Pipelined, multi-lane IEEE-754 add/subtract unit for the vector coprocessor FP functional-unit slot.

---
 rtl/fp_pkg.sv | 45 ++++
 rtl/fp_addsub_lane.sv | 181 ++++++++++++++++++
 rtl/fp_addsub_pipe.sv | 74 +++++++
 tb/tb_fp_addsub_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared format constants, flag indices, operand classes and helpers for the FP add/sub unit.
// Module parameters default to the binary32 constants declared here.
package fp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_W       = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS    = (1 << (FP_EXP_W - 1)) - 1;
  localparam int FP_EXP_MAX = (1 << FP_EXP_W) - 1;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } op_class_e;

  // Canonical quiet NaN for an arbitrary format, right-aligned in 64 bits.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= man_w && i < man_w + exp_w) r[i] = 1'b1;
      if (i == man_w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Leading-zero count over the low 'width' bits of v; returns width when all zero.
  function automatic int lzc(input logic [63:0] v, input int width);
    int n;
    n = width;
    for (int i = 0; i < 64; i++) begin
      if (i < width && v[i]) n = width - 1 - i;
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_addsub_lane.sv
// One lane of the add/sub pipeline: align, add/subtract, normalise/round/pack.
// All stage registers advance together under the shared enable.
module fp_addsub_lane
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sub,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic [EXP_W+MAN_W:0]     y,
  output logic [3:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;
  localparam int EW2  = EXP_W + 2;
  localparam int LZ_W = $clog2(SW + 1);
  localparam logic [63:0] NAN64 = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = NAN64[W-1:0];
  localparam logic signed [EW2-1:0] EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW2-1:0] ONE_E    = 1;
  localparam logic signed [EW2-1:0] ZERO_E   = 0;

  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (m == '0) ? CLS_INF : (m[MAN_W-1] ? CLS_QNAN : CLS_SNAN);
    return CLS_NORM;
  endfunction

  function automatic int sat_shift(input logic [EXP_W-1:0] d);
    return (int'(d) > MAN_W + 3) ? MAN_W + 3 : int'(d);
  endfunction

  function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  logic              sa, sb, sbe, eff_sub_c, a_big, spec_c, nv_c;
  logic [EXP_W-1:0]  ea, eb, el, es;
  logic [MAN_W-1:0]  ma, mb, mda, mdb;
  logic [SW-1:0]     ml_c, ms_c, ms_sh, ms_mask;
  logic [W-1:0]      spec_y_c;
  op_class_e         ca, cb;
  int                sh;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  always_comb begin
    ca        = classify(ea, ma);
    cb        = classify(eb, mb);
    sbe       = sb ^ sub;
    eff_sub_c = sa ^ sbe;
    mda       = (ca == CLS_ZERO) ? '0 : ma;
    mdb       = (cb == CLS_ZERO) ? '0 : mb;
    a_big     = {ea, mda} >= {eb, mdb};
    el        = a_big ? ea : eb;
    es        = a_big ? eb : ea;
    ml_c      = a_big ? {(ea != '0), mda, 3'b000} : {(eb != '0), mdb, 3'b000};
    ms_c      = a_big ? {(eb != '0), mdb, 3'b000} : {(ea != '0), mda, 3'b000};
    sh        = sat_shift(el - es);
    ms_mask   = ~({SW{1'b1}} << sh);
    ms_sh     = ms_c >> sh;
    ms_sh[0]  = ms_sh[0] | (|(ms_c & ms_mask));
    // Specials bypass the datapath; NaN wins over infinity.
    spec_c    = 1'b1;
    spec_y_c  = QNAN;
    nv_c      = (ca == CLS_SNAN) || (cb == CLS_SNAN) ||
                ((ca == CLS_INF) && (cb == CLS_INF) && eff_sub_c);
    if (ca == CLS_QNAN || ca == CLS_SNAN || cb == CLS_QNAN || cb == CLS_SNAN || nv_c)
      spec_y_c = QNAN;
    else if (ca == CLS_INF)
      spec_y_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (cb == CLS_INF)
      spec_y_c = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_c = 1'b0;
  end

  logic             sign_p1, zsign_p1, eff_sub_p1, spec_p1, nv_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [SW-1:0]    ml_p1, ms_p1;
  logic [W-1:0]     spec_y_p1;

  // ---- stage 1: unpack / classify / swap / align
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p1    <= a_big ? sa : sbe;
      zsign_p1   <= sa & sbe;
      eff_sub_p1 <= eff_sub_c;
      exp_p1     <= el;
      ml_p1      <= ml_c;
      ms_p1      <= ms_sh;
      spec_p1    <= spec_c;
      spec_y_p1  <= spec_y_c;
      nv_p1      <= nv_c;
    end
  end

  logic [SW:0] sum_c;
  assign sum_c = eff_sub_p1 ? ({1'b0, ml_p1} - {1'b0, ms_p1})
                            : ({1'b0, ml_p1} + {1'b0, ms_p1});

  logic             sign_p2, zsign_p2, spec_p2, nv_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [SW:0]      sum_p2;
  logic [W-1:0]     spec_y_p2;

  // ---- stage 2: significand add / subtract
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p2   <= sign_p1;
      zsign_p2  <= zsign_p1;
      exp_p2    <= exp_p1;
      sum_p2    <= sum_c;
      spec_p2   <= spec_p1;
      spec_y_p2 <= spec_y_p1;
      nv_p2     <= nv_p1;
    end
  end

  logic [LZ_W-1:0]        lz;
  logic [SW-1:0]          n_c;
  logic signed [EW2-1:0]  e_norm, e_fin;
  logic                   up, inexact;
  logic [MAN_W+1:0]       mant_r;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           y_c;
  logic [3:0]             flags_c;

  always_comb begin
    lz = LZ_W'(lzc(64'(sum_p2[SW-1:0]), SW));
    if (sum_p2[SW]) begin
      n_c    = {sum_p2[SW:2], sum_p2[1] | sum_p2[0]};
      e_norm = $signed({2'b00, exp_p2}) + ONE_E;
    end else begin
      n_c    = sum_p2[SW-1:0] << lz;
      e_norm = $signed({2'b00, exp_p2}) - $signed({{(EW2-LZ_W){1'b0}}, lz});
    end
    up      = rne_up(n_c[3], n_c[2], n_c[1], n_c[0]);
    inexact = |n_c[2:0];
    mant_r  = {1'b0, n_c[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    e_fin   = e_norm + (mant_r[MAN_W+1] ? ONE_E : ZERO_E);
    frac    = mant_r[MAN_W+1] ? '0 : mant_r[MAN_W-1:0];
    flags_c = '0;
    if (spec_p2) begin
      y_c              = spec_y_p2;
      flags_c[FLAG_NV] = nv_p2;
    end else if (sum_p2 == '0) begin
      y_c = {zsign_p2, {(W-1){1'b0}}};
    end else if (e_fin >= EXP_ALL1) begin
      y_c              = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c[FLAG_OF] = 1'b1;
      flags_c[FLAG_NX] = 1'b1;
    end else if (e_fin <= ZERO_E) begin
      y_c              = {sign_p2, {(W-1){1'b0}}};
      flags_c[FLAG_UF] = 1'b1;
      flags_c[FLAG_NX] = 1'b1;
    end else begin
      y_c              = {sign_p2, e_fin[EXP_W-1:0], frac};
      flags_c[FLAG_NX] = inexact;
    end
  end

  // ---- stage 3: normalise / round / pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      flags <= '0;
    end else if (en) begin
      y     <= y_c;
      flags <= flags_c;
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Multi-lane three-stage IEEE-754 add/subtract unit with valid/ready flow control.
// A single global advance signal stalls every lane and the shared valid/tag pipe.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int LANES = 4,
  parameter int TAG_W = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sub,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   in_a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   in_b,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0]   out_y,
  output logic [LANES*4-1:0]                 out_flags,
  output logic [TAG_W-1:0]                   out_tag
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic             adv;
  logic             vld_p1, vld_p2, vld_p3;
  logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3;

  assign adv       = out_ready | ~vld_p3;
  assign in_ready  = adv;
  assign out_valid = vld_p3;
  assign out_tag   = tag_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      tag_p3 <= '0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      tag_p3 <= tag_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      tag_p1 <= in_tag;
      tag_p2 <= tag_p1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_addsub_lane #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .sub   (in_sub),
      .a     (in_a[i*W +: W]),
      .b     (in_b[i*W +: W]),
      .y     (out_y[i*W +: W]),
      .flags (out_flags[i*4 +: 4])
    );
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary32, 4 lanes): directed vectors, latency,
// backpressure streaming and asynchronous reset with groups in flight.
module tb_fp_addsub_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 5;
  localparam int W     = 32;
  localparam int GW    = LANES * W;
  localparam int FW    = LANES * 4;
  localparam int NVEC  = 17;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_sub;
  logic [GW-1:0]    in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [GW-1:0]    out_y;
  logic [FW-1:0]    out_flags;
  logic [TAG_W-1:0] out_tag;

  fp_addsub_pipe #(
    .EXP_W (8),
    .MAN_W (23),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [GW-1:0]    y;
    logic [FW-1:0]    f;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  // Reference vectors for a + b; when sub is used, b is fed with its sign flipped.
  logic [31:0] va [0:NVEC-1] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000,
                                 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001,
                                 32'h40400000, 32'h7FC00000, 32'h7F800000, 32'h00400000,
                                 32'h00800001, 32'h3F800000, 32'hC0A00000, 32'h3F800000,
                                 32'h3F800000};
  logic [31:0] vb [0:NVEC-1] = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'h33800000,
                                 32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h00000000,
                                 32'hC0000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                 32'h80800000, 32'h3F800000, 32'h40400000, 32'hB3800000,
                                 32'hB3000000};
  logic [31:0] vy [0:NVEC-1] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000,
                                 32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                                 32'h3F800000, 32'h7FC00000, 32'h7F800000, 32'h3F800000,
                                 32'h00000000, 32'h40000000, 32'hC0000000, 32'h3F7FFFFF,
                                 32'h3F800000};
  logic [3:0]  vf [0:NVEC-1] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h8, 4'h8,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0,
                                 4'h1};

  // Consumer: random low bursts of 1..5 cycles when enabled.
  initial begin
    int burst;
    burst = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rand_ready) out_ready = 1'b1;
      else if (burst > 0) begin out_ready = 1'b0; burst--; end
      else if ($urandom_range(0, 2) == 0) begin out_ready = 1'b0; burst = int'($urandom_range(0, 4)); end
      else out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each output transfer and checks hold while stalled.
  initial begin
    exp_t             e;
    logic             prev_stall;
    logic [GW-1:0]    prev_y;
    logic [FW-1:0]    prev_f;
    logic [TAG_W-1:0] prev_t;
    prev_stall = 1'b0;
    prev_y = '0; prev_f = '0; prev_t = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_y !== prev_y || out_flags !== prev_f || out_tag !== prev_t) begin
            errors++;
            $display("FAIL stall_hold: valid %b y %h flags %h tag %0d, required held y %h flags %h tag %0d",
                     out_valid, out_y, out_flags, out_tag, prev_y, prev_f, prev_t);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: tag %0d y %h, required no output", out_tag, out_y);
          end else begin
            e = sb.pop_front();
            if (out_y !== e.y) begin
              errors++;
              $display("FAIL result_y: tag %0d got %h required %h", out_tag, out_y, e.y);
            end
            checks++;
            if (out_flags !== e.f) begin
              errors++;
              $display("FAIL result_flags: tag %0d got %h required %h", out_tag, out_flags, e.f);
            end
            checks++;
            if (out_tag !== e.tag) begin
              errors++;
              $display("FAIL result_tag: got %0d required %0d", out_tag, e.tag);
            end
          end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_y = out_y; prev_f = out_flags; prev_t = out_tag;
      end
    end
  end

  // Drives one group built from vector indices; returns at the negedge before the accepting edge.
  task automatic send_idx(input int i0, input int i1, input int i2, input int i3,
                          input logic sub, input logic [TAG_W-1:0] tag);
    int   ids [LANES];
    int   tries;
    exp_t e;
    ids = '{i0, i1, i2, i3};
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sub   = sub;
    in_tag   = tag;
    for (int l = 0; l < LANES; l++) begin
      in_a[l*W +: W]  = va[ids[l]];
      in_b[l*W +: W]  = vb[ids[l]] ^ {sub, 31'h0};
      e.y[l*W +: W]   = vy[ids[l]];
      e.f[l*4 +: 4]   = vf[ids[l]];
    end
    e.tag = tag;
    tries = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready %b, required 1 within 200 cycles", in_ready);
    end else sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if (out_y !== '0) begin errors++; $display("FAIL reset_y: got %h required 0", out_y); end
    checks++; if (out_flags !== '0) begin errors++; $display("FAIL reset_flags: got %h required 0", out_flags); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d required 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_latency();
    int lat;
    send_idx(0, 1, 2, 3, 1'b0, 5'd9);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 3", lat);
    end
    wait_drain();
  endtask

  task automatic test_directed();
    for (int g = 0; g < 5; g++)
      send_idx((4*g) % NVEC, (4*g+1) % NVEC, (4*g+2) % NVEC, (4*g+3) % NVEC,
               g[0], TAG_W'(g + 10));
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back_stall();
    rand_ready = 1'b1;
    for (int t = 0; t < 8; t++)
      send_idx(int'($urandom_range(0, NVEC-1)), int'($urandom_range(0, NVEC-1)),
               int'($urandom_range(0, NVEC-1)), int'($urandom_range(0, NVEC-1)),
               1'($urandom_range(0, 1)), TAG_W'(t));
    idle();
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int stale;
    send_idx(0, 13, 8, 14, 1'b0, 5'd20);
    send_idx(3, 4, 5, 6, 1'b1, 5'd21);
    send_idx(7, 9, 10, 11, 1'b0, 5'd22);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", out_valid); end
    checks++;
    if (out_y !== '0) begin errors++; $display("FAIL midreset_y: got %h required 0", out_y); end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b required 1", in_ready); end
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midreset_stale: %0d valid cycles, required 0", stale); end
    send_idx(0, 0, 0, 0, 1'b0, 5'd23);
    idle();
    wait_drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back_stall();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
